rx_intf_dma_ctl: RTL and testbench
==================================

RX_INTF_DMA_CTL -- requirements
Module: rx_intf_dma_ctl

Interface
REQ-001 Parameter MAX_BIT_NUM_DMA_SYMBOL, default 14: width of symbol counts and FIFO occupancy.
REQ-002 Parameter LEN_QUEUE_DEPTH_BITS, default 2: log2 of the packet-length queue depth (4 entries).
REQ-003 Parameter TIMEOUT_BITS, default 16: width of the stream watchdog counter.
REQ-004 M_AXIS_ACLK  in  1  sole clock; all logic on rising edge.
REQ-005 M_AXIS_ARESETN  in  1  reset, synchronous, active-low.
REQ-006 pkt_end  in  1  one-cycle pulse; the accumulator finished writing one packet into the stream FIFO.
REQ-007 pkt_num_dma_symbol  in  MAX_BIT_NUM_DMA_SYMBOL  beat count minus 1 of that packet, sampled with pkt_end.
REQ-008 data_count  in  MAX_BIT_NUM_DMA_SYMBOL  current stream-FIFO occupancy in 64-bit beats.
REQ-009 tlast_hs  in  1  M_AXIS_TLAST & M_AXIS_TVALID & M_AXIS_TREADY of the stream master.
REQ-010 timeout_cfg  in  TIMEOUT_BITS  watchdog limit in cycles; 0 disables the watchdog.
REQ-011 start_1trans  out  1  start request to the stream master.
REQ-012 M_AXIS_NUM_DMA_SYMBOL  out  MAX_BIT_NUM_DMA_SYMBOL  beat count minus 1 of the transfer in progress.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 len_q_cnt  out  LEN_QUEUE_DEPTH_BITS+1  number of queued packet lengths.
REQ-015 overflow  out  1  sticky; a pkt_end arrived while the queue was full.
REQ-016 timeout  out  1  one-cycle pulse; watchdog expired in STREAM.

Function
REQ-017 The block SHALL push pkt_num_dma_symbol into a FIFO length queue on pkt_end when len_q_cnt < 2^LEN_QUEUE_DEPTH_BITS.
REQ-018 When the queue is full, pkt_end SHALL drop the length, leave the queue unchanged and set overflow.
REQ-019 A push and a pop in the same cycle SHALL both take effect; len_q_cnt stays unchanged.
REQ-020 The FSM SHALL have states IDLE, WAIT_DATA, START, STREAM.
REQ-021 IDLE -> WAIT_DATA when len_q_cnt != 0; in that cycle, latch the queue head into M_AXIS_NUM_DMA_SYMBOL.
REQ-022 WAIT_DATA -> START when data_count >= M_AXIS_NUM_DMA_SYMBOL + 1, computed at MAX_BIT_NUM_DMA_SYMBOL+1 bits with no wrap.
REQ-023 start_1trans SHALL be high exactly one cycle, in START, and low in all other states, so the master always sees a fresh rising edge.
REQ-024 START -> STREAM unconditionally after one cycle.
REQ-025 STREAM -> IDLE on tlast_hs; pop the queue head in that cycle.
REQ-026 M_AXIS_NUM_DMA_SYMBOL SHALL stay constant from WAIT_DATA entry until return to IDLE.
REQ-027 tlast_hs outside STREAM SHALL be ignored.
REQ-028 Back-to-back packets: with len_q_cnt != 0 after the pop, IDLE SHALL last exactly one cycle before WAIT_DATA.

Reset
REQ-029 While M_AXIS_ARESETN is low at a clock edge, state -> IDLE; queue emptied; len_q_cnt, M_AXIS_NUM_DMA_SYMBOL, start_1trans, overflow, timeout -> 0; busy -> 0.
REQ-030 Reset asserted in any state, including mid-STREAM, SHALL abort with no further start_1trans until new pkt_end input arrives.
REQ-031 overflow SHALL clear only on reset.

Configuration
REQ-032 Macro RX_INTF_DMA_CTL_TIMEOUT_EN defined: a watchdog counter SHALL clear on STREAM entry and increment each STREAM cycle.
REQ-033 With RX_INTF_DMA_CTL_TIMEOUT_EN defined, counter == timeout_cfg (timeout_cfg != 0) without tlast_hs SHALL pulse timeout, pop the head and go to IDLE.
REQ-034 With RX_INTF_DMA_CTL_TIMEOUT_EN defined, tlast_hs and expiry in the same cycle SHALL count as normal completion with no timeout pulse.
REQ-035 Macro RX_INTF_DMA_CTL_TIMEOUT_EN undefined: no counter; timeout tied 0; STREAM exits only on tlast_hs; timeout_cfg ignored.

Verification
REQ-036 Single packet: pkt_end with len 15, data_count ramps 0->16 -> start_1trans one pulse the cycle after data_count=16 is seen, NUM_DMA_SYMBOL=15, busy until tlast_hs.
REQ-037 Queue overflow: 5 pkt_end pulses (len 3) with no tlast_hs -> len_q_cnt=4, overflow=1, only the first 4 lengths later served in order.
REQ-038 Back-to-back: lengths 7 then 31 queued, data present -> second start_1trans exactly 3 cycles after the first tlast_hs, NUM_DMA_SYMBOL=31.
REQ-039 Timeout (macro on): timeout_cfg=100, no tlast_hs -> timeout pulse after 100 STREAM cycles, queue popped, FSM in IDLE; macro off -> FSM stays in STREAM.
REQ-040 Reset mid-STREAM: assert reset for one cycle -> all outputs 0, len_q_cnt=0, no start_1trans until a new pkt_end.
REQ-041 Simultaneous push and pop: pkt_end coincident with tlast_hs at len_q_cnt=2 -> len_q_cnt stays 2, new length at tail.

Source files
------------

// File: rtl/rx_intf_dma_ctl.sv
// rx_intf_dma_ctl: packet-length queue plus start sequencer for the RX DMA stream master.
// Optional STREAM watchdog is compiled in when RX_INTF_DMA_CTL_TIMEOUT_EN is defined.
module rx_intf_dma_ctl #(
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
  parameter int LEN_QUEUE_DEPTH_BITS   = 2,
  parameter int TIMEOUT_BITS           = 16
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic                              pkt_end,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] pkt_num_dma_symbol,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count,
  input  logic                              tlast_hs,
  input  logic [TIMEOUT_BITS-1:0]           timeout_cfg,
  output logic                              start_1trans,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] M_AXIS_NUM_DMA_SYMBOL,
  output logic                              busy,
  output logic [LEN_QUEUE_DEPTH_BITS:0]     len_q_cnt,
  output logic                              overflow,
  output logic                              timeout
);

  localparam int QD = 1 << LEN_QUEUE_DEPTH_BITS;
  localparam logic [LEN_QUEUE_DEPTH_BITS-1:0] PTR_ONE = LEN_QUEUE_DEPTH_BITS'(1);
  localparam logic [LEN_QUEUE_DEPTH_BITS:0]   CNT_ONE = (LEN_QUEUE_DEPTH_BITS+1)'(1);
  localparam logic [MAX_BIT_NUM_DMA_SYMBOL:0] SYM_ONE = (MAX_BIT_NUM_DMA_SYMBOL+1)'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    START     = 2'd2,
    STREAM    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] len_mem_q [QD];
  logic [LEN_QUEUE_DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LEN_QUEUE_DEPTH_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEN_QUEUE_DEPTH_BITS:0]     cnt_q, cnt_d;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] num_q, num_d;
  logic                              ovf_q, ovf_d;
  logic                              start_q, start_d;
  logic                              busy_q, busy_d;

  logic q_full;
  logic push;
  logic pop;
  logic done;
  logic expire;

  // Occupancy must cover len_m1 + 1 beats; one extra bit keeps the sum from wrapping.
  function automatic logic data_ready(
    input logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] occ,
    input logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] len_m1
  );
    logic [MAX_BIT_NUM_DMA_SYMBOL:0] need;
    need = {1'b0, len_m1} + SYM_ONE;
    return ({1'b0, occ} >= need);
  endfunction

  // The count only reaches its MSB when every entry is occupied.
  assign q_full = cnt_q[LEN_QUEUE_DEPTH_BITS];
  assign push   = pkt_end && !q_full;
  assign done   = (state_q == STREAM) && (tlast_hs || expire);
  assign pop    = done;

`ifdef RX_INTF_DMA_CTL_TIMEOUT_EN
  localparam logic [TIMEOUT_BITS-1:0] WD_ONE = TIMEOUT_BITS'(1);

  logic [TIMEOUT_BITS-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (state_q == START) begin
      wd_d = '0;
    end else if (state_q == STREAM) begin
      wd_d = wd_q + WD_ONE;
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign expire  = (state_q == STREAM) && (timeout_cfg != '0) && (wd_q == timeout_cfg);
  // A tlast in the expiry cycle wins: treated as a normal completion.
  assign timeout = expire && !tlast_hs;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^timeout_cfg;
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q | (pkt_end & q_full);
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          state_d = WAIT_DATA;
          num_d   = len_mem_q[rd_ptr_q];
        end
      end
      WAIT_DATA: begin
        if (data_ready(data_count, num_q)) begin
          state_d = START;
        end
      end
      START: begin
        state_d = STREAM;
      end
      STREAM: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    start_d = (state_d == START);
    busy_d  = (state_d != IDLE);
  end

  // Length storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (push) begin
      len_mem_q[wr_ptr_q] <= pkt_num_dma_symbol;
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      num_q    <= '0;
      ovf_q    <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      ovf_q    <= ovf_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  assign start_1trans          = start_q;
  assign busy                  = busy_q;
  assign M_AXIS_NUM_DMA_SYMBOL = num_q;
  assign len_q_cnt             = cnt_q;
  assign overflow              = ovf_q;

endmodule

// File: tb/tb_rx_intf_dma_ctl.sv
// Scoreboard bench for rx_intf_dma_ctl: a length-queue reference model feeds expected
// transfer lengths; a negedge monitor checks every start pulse and the queue status.
module tb_rx_intf_dma_ctl;

  localparam int SW = 14;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          arstn;
  logic          pkt_end;
  logic [SW-1:0] pkt_len;
  logic [SW-1:0] data_count;
  logic          tlast_hs;
  logic [15:0]   timeout_cfg;
  logic          start_1trans;
  logic [SW-1:0] num;
  logic          busy;
  logic [2:0]    len_q_cnt;
  logic          overflow;
  logic          timeout;

  // Driver-side intent: this tlast is meant to end the running transfer.
  logic          pop_ok;
  bit            to_expect = 1'b0;

  int            n_checks = 0;
  int            n_fail   = 0;

  int            mcnt = 0;
  bit            movf = 1'b0;
  int            sb[$];
  logic [SW-1:0] dc_at_edge;

  always #5 clk = ~clk;

  rx_intf_dma_ctl #(
    .MAX_BIT_NUM_DMA_SYMBOL(SW),
    .LEN_QUEUE_DEPTH_BITS  (2),
    .TIMEOUT_BITS          (16)
  ) dut (
    .M_AXIS_ACLK          (clk),
    .M_AXIS_ARESETN       (arstn),
    .pkt_end              (pkt_end),
    .pkt_num_dma_symbol   (pkt_len),
    .data_count           (data_count),
    .tlast_hs             (tlast_hs),
    .timeout_cfg          (timeout_cfg),
    .start_1trans         (start_1trans),
    .M_AXIS_NUM_DMA_SYMBOL(num),
    .busy                 (busy),
    .len_q_cnt            (len_q_cnt),
    .overflow             (overflow),
    .timeout              (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) dc_at_edge <= data_count;

  // Reference model: a bounded FIFO of lengths plus a sticky drop flag.
  initial begin
    forever begin
      @(posedge clk);
      if (!arstn) begin
        mcnt = 0;
        movf = 1'b0;
        sb.delete();
      end else begin
        bit full;
        full = (mcnt >= QD);
        if (pop_ok && mcnt > 0) mcnt--;
        if (pkt_end) begin
          if (full) movf = 1'b1;
          else begin
            mcnt++;
            sb.push_back(int'(pkt_len));
          end
        end
      end
    end
  end

  // Monitor: status every cycle, and one expected length consumed per start pulse.
  initial begin
    logic          start_prev;
    logic          busy_prev;
    logic [SW-1:0] num_prev;
    start_prev = 1'b0;
    busy_prev  = 1'b0;
    num_prev   = '0;
    forever begin
      @(negedge clk);
      chk("len_q_cnt", 32'(len_q_cnt), mcnt);
      chk("overflow", 32'(overflow), 32'(movf));
      if (!to_expect) chk("no_timeout", 32'(timeout), 0);
      if (start_1trans === 1'b1) begin
        chk("start_single_cycle", 32'(start_prev), 0);
        chk("start_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          int e;
          e = sb.pop_front();
          chk("num_dma_symbol", 32'(num), e);
          chk("data_ready_at_start", 32'(int'(dc_at_edge) >= e + 1), 1);
          chk("busy_in_start", 32'(busy), 1);
        end
      end
      if (busy_prev === 1'b1 && busy === 1'b1) chk("num_stable", 32'(num), 32'(num_prev));
      start_prev = start_1trans;
      busy_prev  = busy;
      num_prev   = num;
    end
  end

  task automatic cycle();
    @(negedge clk);
    pkt_end  = 1'b0;
    tlast_hs = 1'b0;
    pop_ok   = 1'b0;
  endtask

  task automatic push(input int len);
    pkt_end = 1'b1;
    pkt_len = SW'(len);
    cycle();
  endtask

  task automatic wait_start(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      cycle();
      if (start_1trans === 1'b1) got = 1'b1;
    end
    chk("start_seen", 32'(got), 1);
  endtask

  task automatic serve(input int hold);
    bit got;
    wait_start(200, got);
    if (got) begin
      repeat (hold) cycle();
      tlast_hs = 1'b1;
      pop_ok   = 1'b1;
      cycle();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    bit got;
    bit armed;
    arstn       = 1'b0;
    pkt_end     = 1'b0;
    pkt_len     = '0;
    data_count  = '0;
    tlast_hs    = 1'b0;
    pop_ok      = 1'b0;
    timeout_cfg = '0;
    repeat (3) cycle();
    chk("rst_start", 32'(start_1trans), 0);
    chk("rst_num", 32'(num), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_len_q_cnt", 32'(len_q_cnt), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_timeout", 32'(timeout), 0);
    arstn = 1'b1;
    cycle();

    // Single packet, occupancy ramp up to 16 beats.
    push(15);
    for (int i = 1; i <= 16; i++) begin
      data_count = SW'(i);
      cycle();
      if (i < 16) chk("t1_no_early_start", 32'(start_1trans), 0);
    end
    chk("t1_start_after_dc16", 32'(start_1trans), 1);
    chk("t1_num", 32'(num), 15);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t1_busy_stream", 32'(busy), 1);
      chk("t1_start_low", 32'(start_1trans), 0);
    end
    tlast_hs = 1'b1;
    pop_ok   = 1'b1;
    cycle();
    chk("t1_idle_after_tlast", 32'(busy), 0);
    data_count = '0;

    // Queue overflow: fifth length dropped.
    push(3); push(4); push(5); push(6); push(9);
    chk("t2_q_full", 32'(len_q_cnt), 4);
    chk("t2_overflow", 32'(overflow), 1);
    repeat (5) cycle();
    chk("t2_waiting", 32'(busy), 1);
    data_count = SW'(100);
    for (int i = 0; i < 4; i++) serve(int'($urandom_range(1, 5)));
    repeat (20) cycle();
    chk("t2_drained", 32'(len_q_cnt), 0);
    chk("t2_sb_empty", 32'(sb.size()), 0);
    chk("t2_overflow_sticky", 32'(overflow), 1);

    // Back-to-back: 7 then 31.
    push(7);
    push(31);
    wait_start(200, got);
    repeat (2) cycle();
    tlast_hs = 1'b1;
    pop_ok   = 1'b1;
    cycle();
    chk("t3_idle_one_cycle", 32'(busy), 0);
    chk("t3_no_start_k1", 32'(start_1trans), 0);
    cycle();
    chk("t3_no_start_k2", 32'(start_1trans), 0);
    cycle();
    chk("t3_start_k3", 32'(start_1trans), 1);
    chk("t3_num", 32'(num), 31);
    repeat (2) cycle();
    tlast_hs = 1'b1;
    pop_ok   = 1'b1;
    cycle();

    // Push and pop in the same cycle at two entries.
    data_count = '0;
    push(20);
    push(21);
    data_count = SW'(100);
    wait_start(200, got);
    cycle();
    tlast_hs = 1'b1;
    pop_ok   = 1'b1;
    pkt_end  = 1'b1;
    pkt_len  = SW'(22);
    cycle();
    chk("t4_cnt_stays", 32'(len_q_cnt), 2);
    serve(2);
    serve(3);

    // tlast outside STREAM is ignored.
    data_count = '0;
    tlast_hs   = 1'b1;
    cycle();
    chk("t5_idle_cnt", 32'(len_q_cnt), 0);
    chk("t5_idle_busy", 32'(busy), 0);
    push(5);
    tlast_hs = 1'b1;
    cycle();
    tlast_hs = 1'b1;
    cycle();
    chk("t5_wait_cnt", 32'(len_q_cnt), 1);
    chk("t5_wait_busy", 32'(busy), 1);
    data_count = SW'(100);
    serve(2);

    // Watchdog.
    timeout_cfg = 16'd100;
    push(2);
    wait_start(200, got);
`ifdef RX_INTF_DMA_CTL_TIMEOUT_EN
    to_expect = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      cycle();
      if (k <= 100) chk("t6_no_early_timeout", 32'(timeout), 0);
      else chk("t6_timeout_pulse", 32'(timeout), 1);
    end
    pop_ok = 1'b1;
    cycle();
    chk("t6_idle_after_timeout", 32'(busy), 0);
    chk("t6_timeout_one_cycle", 32'(timeout), 0);
    to_expect = 1'b0;
`else
    for (int k = 0; k < 150; k++) begin
      cycle();
      chk("t6_stays_stream", 32'(busy), 1);
    end
    tlast_hs = 1'b1;
    pop_ok   = 1'b1;
    cycle();
    chk("t6_idle_after_tlast", 32'(busy), 0);
`endif
    timeout_cfg = '0;

    // Reset in the middle of STREAM.
    push(10);
    push(12);
    wait_start(200, got);
    cycle();
    cycle();
    arstn = 1'b0;
    cycle();
    chk("t7_start", 32'(start_1trans), 0);
    chk("t7_num", 32'(num), 0);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_len_q_cnt", 32'(len_q_cnt), 0);
    chk("t7_overflow", 32'(overflow), 0);
    chk("t7_timeout", 32'(timeout), 0);
    arstn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cycle();
      chk("t7_no_start", 32'(start_1trans), 0);
    end
    push(13);
    serve(3);

    // Randomized traffic.
    armed = 1'b0;
    for (int c = 0; c < 600; c++) begin
      cycle();
      if (armed && $urandom_range(0, 3) == 0) begin
        tlast_hs = 1'b1;
        pop_ok   = 1'b1;
        armed    = 1'b0;
      end else if (!armed && $urandom_range(0, 9) == 0) begin
        tlast_hs = 1'b1;
      end
      if (start_1trans === 1'b1) armed = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        pkt_end = 1'b1;
        pkt_len = SW'($urandom_range(0, 60));
      end
      data_count = SW'($urandom_range(0, 80));
    end
    data_count = SW'(200);
    for (int c = 0; c < 2000 && (mcnt > 0 || armed); c++) begin
      cycle();
      if (armed) begin
        tlast_hs = 1'b1;
        pop_ok   = 1'b1;
        armed    = 1'b0;
      end
      if (start_1trans === 1'b1) armed = 1'b1;
    end
    repeat (3) cycle();
    chk("rand_drained", 32'(len_q_cnt), 0);
    chk("rand_sb_empty", 32'(sb.size()), 0);
    chk("rand_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
